// File: rtl/fp_mult_norm.sv
// rtl/fp_mult_norm.sv - binary32 significand shift-add multiplier with product normalization
//
// Sequential front end of the single-precision multiplier. It accepts an operand
// pair on the in_valid/in_ready handshake and builds the 48-bit significand
// product over 24 shift-add iterations. It then normalizes the product and holds
// the rounding-stage inputs on the out_valid/out_ready handshake.
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   in_valid, in_ready   operand handshake (in_ready depends on state only)
//   a, b, rnd            binary32 operands and rounding mode, captured on accept
//   out_valid, out_ready result handshake
//   mantissa, guard,     normalized 24-bit significand (bit 23 = hidden 1),
//   sticky               first dropped bit, OR of all lower dropped bits
//   sign_mult, exp_norm  product sign, 10-bit signed biased exponent
//   rnd_out              captured rounding mode
//   zero, special        exponent-field-0 operand / exponent-field-0xFF operand

package rnd_enum;
   typedef enum logic [2:0] {
      RNE = 3'd0,
      RTZ = 3'd1,
      RDN = 3'd2,
      RUP = 3'd3,
      RMM = 3'd4
   } rnd_t;
endpackage

module fp_mult_norm (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [31:0]        a,
   input  logic [31:0]        b,
   input  rnd_enum::rnd_t     rnd,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [23:0]        mantissa,
   output logic               guard,
   output logic               sticky,
   output logic               sign_mult,
   output logic [9:0]         exp_norm,
   output rnd_enum::rnd_t     rnd_out,
   output logic               zero,
   output logic               special
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MULT = 2'd1,
      NORM = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t           state_q, state_d;

   // operand and iteration state
   logic [23:0]      ma_q, ma_d;
   logic [23:0]      mb_q, mb_d;
   logic [47:0]      acc_q, acc_d;
   logic [4:0]       cnt_q, cnt_d;
   logic [7:0]       ea_q, ea_d;
   logic [7:0]       eb_q, eb_d;
   logic             op_sign_q, op_sign_d;
   logic             op_zero_q, op_zero_d;
   logic             op_special_q, op_special_d;
   rnd_enum::rnd_t   op_rnd_q, op_rnd_d;

   // registered result
   logic [23:0]      mantissa_q, mantissa_d;
   logic             guard_q, guard_d;
   logic             sticky_q, sticky_d;
   logic             sign_q, sign_d;
   logic [9:0]       exp_q, exp_d;
   rnd_enum::rnd_t   rnd_out_q, rnd_out_d;
   logic             zero_q, zero_d;
   logic             special_q, special_d;

   // exponent sum cannot exceed 510, so 10 bits hold it and the -127 bias
   // adjustment without wrapping (range -125..382)
   logic [9:0]       exp_sum;
   logic [47:0]      addend;

   assign exp_sum = {2'b00, ea_q} + {2'b00, eb_q};
   assign addend  = {24'd0, ma_q} << cnt_q;

   always_comb begin
      state_d      = state_q;
      ma_d         = ma_q;
      mb_d         = mb_q;
      acc_d        = acc_q;
      cnt_d        = cnt_q;
      ea_d         = ea_q;
      eb_d         = eb_q;
      op_sign_d    = op_sign_q;
      op_zero_d    = op_zero_q;
      op_special_d = op_special_q;
      op_rnd_d     = op_rnd_q;
      mantissa_d   = mantissa_q;
      guard_d      = guard_q;
      sticky_d     = sticky_q;
      sign_d       = sign_q;
      exp_d        = exp_q;
      rnd_out_d    = rnd_out_q;
      zero_d       = zero_q;
      special_d    = special_q;

      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               ma_d         = {1'b1, a[22:0]};
               mb_d         = {1'b1, b[22:0]};
               acc_d        = 48'd0;
               cnt_d        = 5'd0;
               ea_d         = a[30:23];
               eb_d         = b[30:23];
               op_sign_d    = a[31] ^ b[31];
               // subnormals are flushed: any zero exponent field means zero
               op_zero_d    = (a[30:23] == 8'h00) || (b[30:23] == 8'h00);
               op_special_d = (a[30:23] == 8'hFF) || (b[30:23] == 8'hFF);
               op_rnd_d     = rnd;
               state_d      = MULT;
            end
         end
         MULT: begin
            if (mb_q[0]) begin
               acc_d = acc_q + addend;
            end
            mb_d  = mb_q >> 1;
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd23) begin
               state_d = NORM;
            end
         end
         NORM: begin
            // product of two [1,2) significands lies in [1,4): bit 47 picks the shift
            if (acc_q[47]) begin
               mantissa_d = acc_q[47:24];
               guard_d    = acc_q[23];
               sticky_d   = |acc_q[22:0];
               exp_d      = exp_sum - 10'd126;
            end else begin
               mantissa_d = acc_q[46:23];
               guard_d    = acc_q[22];
               sticky_d   = |acc_q[21:0];
               exp_d      = exp_sum - 10'd127;
            end
            if (op_zero_q) begin
               mantissa_d = 24'd0;
               guard_d    = 1'b0;
               sticky_d   = 1'b0;
               exp_d      = 10'd0;
            end
            sign_d    = op_sign_q;
            rnd_out_d = op_rnd_q;
            zero_d    = op_zero_q;
            special_d = op_special_q;
            state_d   = DONE;
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         ma_q         <= 24'd0;
         mb_q         <= 24'd0;
         acc_q        <= 48'd0;
         cnt_q        <= 5'd0;
         ea_q         <= 8'd0;
         eb_q         <= 8'd0;
         op_sign_q    <= 1'b0;
         op_zero_q    <= 1'b0;
         op_special_q <= 1'b0;
         op_rnd_q     <= rnd_enum::RNE;
         mantissa_q   <= 24'd0;
         guard_q      <= 1'b0;
         sticky_q     <= 1'b0;
         sign_q       <= 1'b0;
         exp_q        <= 10'd0;
         rnd_out_q    <= rnd_enum::RNE;
         zero_q       <= 1'b0;
         special_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         ma_q         <= ma_d;
         mb_q         <= mb_d;
         acc_q        <= acc_d;
         cnt_q        <= cnt_d;
         ea_q         <= ea_d;
         eb_q         <= eb_d;
         op_sign_q    <= op_sign_d;
         op_zero_q    <= op_zero_d;
         op_special_q <= op_special_d;
         op_rnd_q     <= op_rnd_d;
         mantissa_q   <= mantissa_d;
         guard_q      <= guard_d;
         sticky_q     <= sticky_d;
         sign_q       <= sign_d;
         exp_q        <= exp_d;
         rnd_out_q    <= rnd_out_d;
         zero_q       <= zero_d;
         special_q    <= special_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign mantissa  = mantissa_q;
   assign guard     = guard_q;
   assign sticky    = sticky_q;
   assign sign_mult = sign_q;
   assign exp_norm  = exp_q;
   assign rnd_out   = rnd_out_q;
   assign zero      = zero_q;
   assign special   = special_q;

endmodule
